// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl
//   Row-scan controller for the 7x5 LED matrix. A double-buffered frame store
//   is filled through the write port (back bank) while the front bank is
//   multiplexed onto rowOut/colOut one row at a time, each row preceded by a
//   blanking gap. Front/back swaps commit only on frame boundaries (or right
//   away while idle), so a frame never tears.
//
// Ports
//   CLK, reset        clock, async active-high reset
//   enable            1 = scan running, 0 = dark/idle
//   wr_en/wr_row/
//   wr_data           back-bank row write (wr_row >= ROWS ignored)
//   swap_req          swap request pulse (held pending until commit)
//   swap_ack          one-cycle pulse when a swap commits
//   frame_start       one-cycle pulse on entry to BLANK of row 0
//   scan_row          row currently in BLANK/DRIVE
//   rowOut/colOut     matrix drive lines (registered)
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | scan stopped, all lines inactive, swaps commit at once
// ST_BLANK | all lines inactive before row scan_row
// ST_DRIVE | row scan_row driven with its latched pixel data
module matrix_scan_ctrl #(
  parameter int   ROWS   = 7,
  parameter int   COLS   = 5,
  parameter int   DWELL  = 50000,
  parameter int   BLANK  = 200,
  parameter logic ROW_ON = 1'b1,
  parameter logic COL_ON = 1'b0
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            enable,
  input  logic            wr_en,
  input  logic [2:0]      wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            swap_req,
  output logic            swap_ack,
  output logic            frame_start,
  output logic [2:0]      scan_row,
  output logic [ROWS-1:0] rowOut,
  output logic [COLS-1:0] colOut
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [2:0]    LAST_ROW = 3'(ROWS - 1);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      scan_row_q, scan_row_d;
  logic [COLS-1:0] row_lat_q, row_lat_d;
  logic            front_q, front_d;
  logic            pending_q, pending_d;
  logic            swap_ack_q, swap_ack_d;
  logic            frame_start_q, frame_start_d;
  logic [ROWS-1:0] row_out_q, row_out_d;
  logic [COLS-1:0] col_out_q, col_out_d;
  logic [COLS-1:0] bank0_q [ROWS];
  logic [COLS-1:0] bank0_d [ROWS];
  logic [COLS-1:0] bank1_q [ROWS];
  logic [COLS-1:0] bank1_d [ROWS];
  logic            commit;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    scan_row_d    = scan_row_q;
    row_lat_d     = row_lat_q;
    front_d       = front_q;
    pending_d     = pending_q | swap_req;
    swap_ack_d    = 1'b0;
    frame_start_d = 1'b0;
    bank0_d       = bank0_q;
    bank1_d       = bank1_q;
    commit        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        scan_row_d = '0;
        cnt_d      = '0;
        commit     = pending_q;
        if (enable) begin
          state_d       = ST_BLANK;
          cnt_d         = BLANK_LD;
          frame_start_d = 1'b1;
        end
      end
      ST_BLANK: begin
        if (cnt_q == '0) begin
          state_d   = ST_DRIVE;
          cnt_d     = DWELL_LD;
          // Row data is frozen here so a later swap cannot alter this row.
          row_lat_d = front_q ? bank1_q[scan_row_q] : bank0_q[scan_row_q];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_BLANK;
          cnt_d   = BLANK_LD;
          if (scan_row_q == LAST_ROW) begin
            scan_row_d    = '0;
            frame_start_d = 1'b1;
            commit        = pending_q;
          end else begin
            scan_row_d = scan_row_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) begin
      state_d       = ST_IDLE;
      cnt_d         = '0;
      scan_row_d    = '0;
      frame_start_d = 1'b0;
      // Boundary commits need a running scan; idle commits do not.
      if (state_q != ST_IDLE) commit = 1'b0;
    end

    if (commit) begin
      front_d    = ~front_q;
      pending_d  = swap_req;   // a request in the commit cycle waits for the next boundary
      swap_ack_d = 1'b1;
    end

    // Writes target the back bank as seen before any swap this cycle.
    if (wr_en && (32'(wr_row) < ROWS)) begin
      if (front_q) bank0_d[wr_row] = wr_data;
      else         bank1_d[wr_row] = wr_data;
    end

    row_out_d = {ROWS{~ROW_ON}};
    col_out_d = {COLS{~COL_ON}};
    if (state_d == ST_DRIVE) begin
      row_out_d[scan_row_d] = ROW_ON;
      for (int c = 0; c < COLS; c++)
        col_out_d[c] = row_lat_d[c] ? COL_ON : ~COL_ON;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      scan_row_q    <= '0;
      row_lat_q     <= '0;
      front_q       <= 1'b0;
      pending_q     <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      row_out_q     <= {ROWS{~ROW_ON}};
      col_out_q     <= {COLS{~COL_ON}};
      bank0_q       <= '{default: '0};
      bank1_q       <= '{default: '0};
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      scan_row_q    <= scan_row_d;
      row_lat_q     <= row_lat_d;
      front_q       <= front_d;
      pending_q     <= pending_d;
      swap_ack_q    <= swap_ack_d;
      frame_start_q <= frame_start_d;
      row_out_q     <= row_out_d;
      col_out_q     <= col_out_d;
      bank0_q       <= bank0_d;
      bank1_q       <= bank1_d;
    end
  end

  assign swap_ack    = swap_ack_q;
  assign frame_start = frame_start_q;
  assign scan_row    = scan_row_q;
  assign rowOut      = row_out_q;
  assign colOut      = col_out_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl with ROWS=7, COLS=5, DWELL=4, BLANK=2.
// Position k counts cycles from a frame start: row = (k%42)/6, the first two
// cycles of each row are blank, the next four drive it.
module tb_matrix_scan_ctrl;

  logic       CLK = 1'b0;
  logic       reset;
  logic       enable;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [4:0] wr_data;
  logic       swap_req;
  logic       swap_ack;
  logic       frame_start;
  logic [2:0] scan_row;
  logic [6:0] rowOut;
  logic [4:0] colOut;

  int n_chk = 0;
  int n_bad = 0;
  logic [4:0] exp_pix [7];

  matrix_scan_ctrl #(
    .ROWS(7), .COLS(5), .DWELL(4), .BLANK(2), .ROW_ON(1'b1), .COL_ON(1'b0)
  ) dut (
    .CLK(CLK), .reset(reset), .enable(enable),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .frame_start(frame_start),
    .scan_row(scan_row), .rowOut(rowOut), .colOut(colOut)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Checks positions k0..k1-1, advancing one clock after each.
  task automatic scan_check(input int k0, input int k1, input int ack_k);
    int f, r, ph;
    logic [6:0] er;
    logic [4:0] ec;
    for (int k = k0; k < k1; k++) begin
      f  = k % 42;
      r  = f / 6;
      ph = f % 6;
      er = (ph >= 2) ? 7'(1 << r) : 7'h00;
      ec = (ph >= 2) ? ~exp_pix[r] : 5'h1F;
      chk($sformatf("rowOut k=%0d", k), 32'(rowOut), 32'(er));
      chk($sformatf("colOut k=%0d", k), 32'(colOut), 32'(ec));
      chk($sformatf("scan_row k=%0d", k), 32'(scan_row), 32'(r));
      chk($sformatf("frame_start k=%0d", k), 32'(frame_start), 32'(f == 0));
      chk($sformatf("swap_ack k=%0d", k), 32'(swap_ack), 32'(k == ack_k));
      tick();
    end
  endtask

  task automatic pix_clear();
    for (int i = 0; i < 7; i++) exp_pix[i] = 5'h00;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_row = 3'd0;
    wr_data = 5'h00; swap_req = 1'b0;
    pix_clear();
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst rowOut", 32'(rowOut), 32'h00);
    chk("rst colOut", 32'(colOut), 32'h1F);
    chk("rst swap_ack", 32'(swap_ack), 32'h0);
    chk("rst frame_start", 32'(frame_start), 32'h0);
    chk("rst scan_row", 32'(scan_row), 32'h0);
    tick();
    chk("idle rowOut", 32'(rowOut), 32'h00);

    // empty banks: row walk over a frame and into the next
    enable = 1'b1;
    tick();
    scan_check(0, 48, -1);

    // write back row 0, swap mid-frame, visible next frame
    wr_en = 1'b1; wr_row = 3'd0; wr_data = 5'b10101;
    tick();
    wr_en = 1'b0; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    scan_check(50, 84, -1);
    exp_pix[0] = 5'b10101;
    scan_check(84, 126, 84);

    // drop enable during row 3 DRIVE, then restart
    scan_check(126, 147, -1);
    enable = 1'b0;
    tick();
    chk("dis rowOut", 32'(rowOut), 32'h00);
    chk("dis colOut", 32'(colOut), 32'h1F);
    chk("dis scan_row", 32'(scan_row), 32'h0);
    chk("dis frame_start", 32'(frame_start), 32'h0);
    tick();
    chk("dis2 rowOut", 32'(rowOut), 32'h00);
    enable = 1'b1;
    tick();
    scan_check(0, 8, -1);

    // idle: out-of-range write ignored, swap commits one cycle after pending
    enable = 1'b0;
    tick();
    wr_en = 1'b1; wr_row = 3'd7; wr_data = 5'h1F;
    tick();
    wr_en = 1'b0; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("idle swap pend", 32'(swap_ack), 32'h0);
    tick();
    chk("idle swap ack", 32'(swap_ack), 32'h1);
    tick();
    chk("idle swap ack end", 32'(swap_ack), 32'h0);
    chk("idle rowOut", 32'(rowOut), 32'h00);

    // front is the all-zero bank again; back holds row0=10101
    pix_clear();
    enable = 1'b1;
    tick();
    scan_check(0, 3, -1);
    wr_en = 1'b1; wr_row = 3'd5; wr_data = 5'h1F;   // back only: row 5 stays dark now
    scan_check(3, 4, -1);
    wr_en = 1'b0;
    scan_check(4, 10, -1);
    swap_req = 1'b1;
    scan_check(10, 11, -1);
    swap_req = 1'b0;
    scan_check(11, 41, -1);
    // write and a new request in the commit cycle
    wr_en = 1'b1; wr_row = 3'd3; wr_data = 5'b11000; swap_req = 1'b1;
    scan_check(41, 42, -1);
    wr_en = 1'b0; swap_req = 1'b0;
    exp_pix[0] = 5'b10101;
    exp_pix[3] = 5'b11000;
    exp_pix[5] = 5'h1F;
    scan_check(42, 84, 42);
    pix_clear();
    scan_check(84, 92, 84);

    // async reset mid-DRIVE of row 1
    chk("pre-rst rowOut", 32'(rowOut), 32'h02);
    reset = 1'b1;
    #1;
    chk("arst rowOut", 32'(rowOut), 32'h00);
    chk("arst colOut", 32'(colOut), 32'h1F);
    chk("arst swap_ack", 32'(swap_ack), 32'h0);
    chk("arst scan_row", 32'(scan_row), 32'h0);
    tick();
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
